// File: rtl/maxpool_cif_0_2_win_addr_gen.sv
// Window address generator for the CIF_0_2 max-pool stage: walks every POOLxPOOL window
// and streams one linear element address per beat. Optional bounds check: MAXPOOL_ADDR_BOUNDS_CHK_EN.
module maxpool_cif_0_2_win_addr_gen #(
    parameter int IN_W   = 28,
    parameter int IN_H   = 28,
    parameter int CH     = 6,
    parameter int POOL   = 2,
    parameter int ADDR_W = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_done,
    output logic              ap_ready,
    output logic [31:0]       mul_din0,
    output logic [30:0]       mul_din1,
    output logic              mul_ce,
    input  logic [62:0]       mul_dout,
    output logic [ADDR_W-1:0] addr_tdata,
    output logic              addr_tvalid,
    input  logic              addr_tready,
    output logic              addr_tlast,
    output logic              err
);

    localparam int OUT_W = IN_W / POOL;
    localparam int OUT_H = IN_H / POOL;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_CAPT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [31:0] kx_reg, kx_next;
    logic [31:0] ky_reg, ky_next;
    logic [31:0] ox_reg, ox_next;
    logic [31:0] oy_reg, oy_next;
    logic [31:0] c_reg, c_next;
    logic [31:0] din0_reg, din0_next;
    logic [30:0] din1_reg, din1_next;
    logic [ADDR_W-1:0] row_base_reg, row_base_next;
    logic [ADDR_W-1:0] addr;
    logic              beat;
    logic              unused_dout_bits;

    // Only the low ADDR_W bits of the row product form the address.
    assign unused_dout_bits = ^mul_dout[62:ADDR_W];

    assign beat = (state_reg == S_EMIT) && addr_tready;
    assign addr = row_base_reg + ADDR_W'(ox_reg * 32'(POOL) + kx_reg);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_reg    <= S_IDLE;
            kx_reg       <= '0;
            ky_reg       <= '0;
            ox_reg       <= '0;
            oy_reg       <= '0;
            c_reg        <= '0;
            din0_reg     <= '0;
            din1_reg     <= '0;
            row_base_reg <= '0;
        end else begin
            state_reg    <= state_next;
            kx_reg       <= kx_next;
            ky_reg       <= ky_next;
            ox_reg       <= ox_next;
            oy_reg       <= oy_next;
            c_reg        <= c_next;
            din0_reg     <= din0_next;
            din1_reg     <= din1_next;
            row_base_reg <= row_base_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        kx_next       = kx_reg;
        ky_next       = ky_reg;
        ox_next       = ox_reg;
        oy_next       = oy_reg;
        c_next        = c_reg;
        din0_next     = din0_reg;
        din1_next     = din1_reg;
        row_base_next = row_base_reg;
        case (state_reg)
            S_IDLE: begin
                if (ap_start) begin
                    state_next = S_MUL;
                    kx_next    = '0;
                    ky_next    = '0;
                    ox_next    = '0;
                    oy_next    = '0;
                    c_next     = '0;
                    din0_next  = '0;
                    din1_next  = 31'(IN_W);
                end
            end
            S_MUL: state_next = S_CAPT;
            S_CAPT: begin
                row_base_next = mul_dout[ADDR_W-1:0];
                state_next    = S_EMIT;
            end
            S_EMIT: begin
                if (addr_tready) begin
                    if (kx_reg < 32'(POOL - 1)) begin
                        kx_next = kx_reg + 32'd1;
                    end else begin
                        // Row segment finished: advance the outer counters and fetch the next row base.
                        kx_next    = '0;
                        state_next = S_MUL;
                        if (ky_reg < 32'(POOL - 1)) begin
                            ky_next = ky_reg + 32'd1;
                        end else begin
                            ky_next = '0;
                            if (ox_reg < 32'(OUT_W - 1)) begin
                                ox_next = ox_reg + 32'd1;
                            end else begin
                                ox_next = '0;
                                if (oy_reg < 32'(OUT_H - 1)) begin
                                    oy_next = oy_reg + 32'd1;
                                end else begin
                                    oy_next = '0;
                                    if (c_reg < 32'(CH - 1)) begin
                                        c_next = c_reg + 32'd1;
                                    end else begin
                                        c_next     = '0;
                                        state_next = S_DONE;
                                    end
                                end
                            end
                        end
                        if (state_next == S_MUL) begin
                            din0_next = c_next * 32'(IN_H) + oy_next * 32'(POOL) + ky_next;
                            din1_next = 31'(IN_W);
                        end
                    end
                end
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign ap_idle     = (state_reg == S_IDLE);
    assign ap_done     = (state_reg == S_DONE);
    assign ap_ready    = (state_reg == S_DONE);
    assign mul_ce      = (state_reg == S_MUL);
    assign mul_din0    = din0_reg;
    assign mul_din1    = din1_reg;
    assign addr_tvalid = (state_reg == S_EMIT);
    assign addr_tdata  = addr;
    assign addr_tlast  = (state_reg == S_EMIT) && (kx_reg == 32'(POOL - 1)) && (ky_reg == 32'(POOL - 1));

`ifdef MAXPOOL_ADDR_BOUNDS_CHK_EN
    localparam logic [63:0] ADDR_LIMIT = 64'(CH) * 64'(IN_H) * 64'(IN_W);

    logic err_reg;

    // Sticky across the frame; cleared only when a new frame is accepted.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            err_reg <= 1'b0;
        end else if ((state_reg == S_IDLE) && ap_start) begin
            err_reg <= 1'b0;
        end else if (beat && (64'(addr) >= ADDR_LIMIT)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    logic unused_beat;
    assign unused_beat = beat;
    assign err = 1'b0;
`endif

endmodule
